// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU I/O port.
package vdp_pkg;

    localparam logic [7:0] PORT_DATA_OFS = 8'd0;
    localparam logic [7:0] PORT_CTRL_OFS = 8'd1;

    typedef enum logic {
        LATCH_FIRST  = 1'b0,
        LATCH_SECOND = 1'b1
    } latch_t;

    localparam int STATUS_F_BIT = 7;
    localparam int IE_REG       = 1;
    localparam int IE_BIT       = 5;
    localparam int HIADDR_REG   = 14;

endpackage

// File: rtl/vdp_cpu_port_if.sv
// CPU I/O bus as seen by the VDP port: the CPU side is the master.
interface vdp_cpu_port_if;

    logic [7:0] io_addr;
    logic       io_rd_n;
    logic       io_wr_n;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       io_sel;

    modport master (output io_addr, io_rd_n, io_wr_n, io_din,
                    input  io_dout, io_sel);
    modport slave  (input  io_addr, io_rd_n, io_wr_n, io_din,
                    output io_dout, io_sel);

endinterface

// File: rtl/io_strobe_edge.sv
// One access per strobe assertion: fires on the first clk_ena cycle with the
// strobe low and the address qualifier true, re-arms once the strobe is seen high.
module io_strobe_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_ena,
    input  logic strobe_n,
    input  logic qual,
    output logic pulse
);

    logic armed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            armed <= 1'b1;
        end else if (clk_ena) begin
            if (strobe_n)
                armed <= 1'b1;
            else if (qual)
                armed <= 1'b0;
        end
    end

    assign pulse = clk_ena & ~strobe_n & armed & qual;

endmodule

// File: rtl/vdp_cpu_port.sv
// VDP CPU-side port: two-byte control latch, register file, VRAM address
// auto-increment with read prefetch, and the frame-interrupt status flag.
//
// state        | meaning
// LATCH_FIRST  | next control write is stored as first_byte
// LATCH_SECOND | next control write selects register write or address load
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter logic [7:0] PORT_BASE = 8'h98,
    parameter int         NUM_REGS  = 8,
    parameter int         VRAM_AW   = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_ena,
    vdp_cpu_port_if.slave         cpu,
    output logic [VRAM_AW-1:0]    vram_addr,
    output logic                  vram_we,
    output logic                  vram_re,
    output logic [7:0]            vram_wdata,
    input  logic [7:0]            vram_rdata,
    input  logic                  vram_rvalid,
    output logic [NUM_REGS*8-1:0] regs,
    input  logic                  vblank,
    output logic                  int_n
);

    localparam logic [7:0]         DATA_PORT = PORT_BASE + PORT_DATA_OFS;
    localparam logic [7:0]         CTRL_PORT = PORT_BASE + PORT_CTRL_OFS;
    localparam logic [VRAM_AW-1:0] ADDR_ONE  = VRAM_AW'(1);

    logic               hit_data, hit_ctrl, hit_any;
    logic               rd_acc, wr_acc;
    logic               data_wr, data_rd, ctrl_wr, stat_rd;
    latch_t             latch;
    logic [7:0]         din, first_byte, read_buf, status;
    logic               flag_f, pending, inc_pend;
    logic [VRAM_AW-1:0] addr_now, load_addr;

    assign din      = cpu.io_din;
    assign hit_data = (cpu.io_addr == DATA_PORT);
    assign hit_ctrl = (cpu.io_addr == CTRL_PORT);
    assign hit_any  = hit_data | hit_ctrl;

    io_strobe_edge u_rd_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_ena  (clk_ena),
        .strobe_n (cpu.io_rd_n),
        .qual     (hit_any),
        .pulse    (rd_acc)
    );

    io_strobe_edge u_wr_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_ena  (clk_ena),
        .strobe_n (cpu.io_wr_n),
        .qual     (hit_any),
        .pulse    (wr_acc)
    );

    assign data_wr = wr_acc & hit_data;
    assign ctrl_wr = wr_acc & hit_ctrl;
    assign data_rd = rd_acc & hit_data;
    assign stat_rd = rd_acc & hit_ctrl;

    always_comb begin
        status               = '0;
        status[STATUS_F_BIT] = flag_f;
    end

    assign cpu.io_sel  = ~cpu.io_rd_n & hit_any;
    assign cpu.io_dout = hit_ctrl ? status : read_buf;

    // A data write holds the address for its vram_we cycle and bumps it one cycle later.
    assign addr_now = inc_pend ? vram_addr + ADDR_ONE : vram_addr;

    generate
        if (VRAM_AW > 14) begin : g_hi_addr
            assign load_addr = {regs[HIADDR_REG*8 +: VRAM_AW-14], din[5:0], first_byte};
        end else begin : g_lo_addr
            assign load_addr = {din[5:0], first_byte};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs       <= '0;
            vram_addr  <= '0;
            first_byte <= '0;
            read_buf   <= '0;
            flag_f     <= 1'b0;
            pending    <= 1'b0;
            inc_pend   <= 1'b0;
            latch      <= LATCH_FIRST;
            vram_we    <= 1'b0;
            vram_re    <= 1'b0;
            vram_wdata <= '0;
            int_n      <= 1'b1;
        end else begin
            vram_we   <= 1'b0;
            vram_re   <= 1'b0;
            inc_pend  <= 1'b0;
            vram_addr <= addr_now;
            int_n     <= ~(flag_f & regs[IE_REG*8 + IE_BIT]);

            // vblank wins over a status read in the same cycle
            if (vblank)
                flag_f <= 1'b1;
            else if (stat_rd)
                flag_f <= 1'b0;

            if (pending && vram_rvalid) begin
                read_buf <= vram_rdata;
                pending  <= 1'b0;
            end

            if (data_wr || data_rd || stat_rd)
                latch <= LATCH_FIRST;

            if (ctrl_wr) begin
                if (latch == LATCH_FIRST) begin
                    first_byte <= din;
                    latch      <= LATCH_SECOND;
                end else begin
                    latch <= LATCH_FIRST;
                    if (din[7]) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (din[5:0] == 6'(i))
                                regs[i*8 +: 8] <= first_byte;
                    end else begin
                        vram_addr <= load_addr;
                        if (!din[6]) begin
                            vram_re <= 1'b1;
                            pending <= 1'b1;
                        end
                    end
                end
            end

            if (data_wr) begin
                vram_we    <= 1'b1;
                vram_wdata <= din;
                read_buf   <= din;
                pending    <= 1'b0;
                inc_pend   <= 1'b1;
            end

            if (data_rd) begin
                vram_addr <= addr_now + ADDR_ONE;
                vram_re   <= 1'b1;
                pending   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: default instance plus a 17-bit address
// instance sharing the same CPU traffic.
module tb_vdp_cpu_port;

    logic clk = 1'b0;
    logic reset_n, clk_ena, vblank;

    logic [13:0]  vram_addr;
    logic         vram_we, vram_re;
    logic [7:0]   vram_wdata, vram_rdata;
    logic         vram_rvalid;
    logic [63:0]  regs;
    logic         int_n;

    logic [16:0]  vram_addr17;
    logic         vram_we17, vram_re17;
    logic [7:0]   vram_wdata17;
    logic [7:0]   rdata17;
    logic         rvalid17;
    logic [127:0] regs17;
    logic         int_n17;

    vdp_cpu_port_if cpu ();
    vdp_cpu_port_if cpu17 ();

    assign cpu17.io_addr = cpu.io_addr;
    assign cpu17.io_rd_n = cpu.io_rd_n;
    assign cpu17.io_wr_n = cpu.io_wr_n;
    assign cpu17.io_din  = cpu.io_din;

    vdp_cpu_port dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_ena     (clk_ena),
        .cpu         (cpu),
        .vram_addr   (vram_addr),
        .vram_we     (vram_we),
        .vram_re     (vram_re),
        .vram_wdata  (vram_wdata),
        .vram_rdata  (vram_rdata),
        .vram_rvalid (vram_rvalid),
        .regs        (regs),
        .vblank      (vblank),
        .int_n       (int_n)
    );

    vdp_cpu_port #(.NUM_REGS(16), .VRAM_AW(17)) dut17 (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_ena     (clk_ena),
        .cpu         (cpu17),
        .vram_addr   (vram_addr17),
        .vram_we     (vram_we17),
        .vram_re     (vram_re17),
        .vram_wdata  (vram_wdata17),
        .vram_rdata  (rdata17),
        .vram_rvalid (rvalid17),
        .regs        (regs17),
        .vblank      (vblank),
        .int_n       (int_n17)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          we_cnt = 0;
    int          re_cnt = 0;
    logic [13:0] we_addr, re_addr;
    logic [7:0]  we_data;

    always @(negedge clk) begin
        if (vram_we) begin
            we_cnt++;
            we_addr = vram_addr;
            we_data = vram_wdata;
        end
        if (vram_re) begin
            re_cnt++;
            re_addr = vram_addr;
        end
    end

    // memory: content is addr[7:0]^A5, answers after mem_lat cycles, in order
    int         mem_lat = 3;
    int         cyc = 0;
    int         due_q[$];
    logic [7:0] dat_q[$];

    function automatic logic [7:0] mem_val(input logic [13:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    initial begin
        vram_rvalid = 1'b0;
        vram_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            vram_rvalid = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                vram_rvalid = 1'b1;
                vram_rdata  = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            if (vram_re) begin
                due_q.push_back(cyc + mem_lat);
                dat_q.push_back(mem_val(vram_addr));
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu.io_addr = a;
        cpu.io_din  = d;
        cpu.io_wr_n = 1'b0;
        @(negedge clk);
        cpu.io_wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic io_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu.io_addr = a;
        cpu.io_rd_n = 1'b0;
        #1 d = cpu.io_dout;
        @(negedge clk);
        cpu.io_rd_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int we0, re0;

        reset_n     = 1'b0;
        clk_ena     = 1'b1;
        vblank      = 1'b0;
        rdata17     = 8'h00;
        rvalid17    = 1'b0;
        cpu.io_addr = 8'h00;
        cpu.io_din  = 8'h00;
        cpu.io_rd_n = 1'b1;
        cpu.io_wr_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cpu.io_addr = 8'h98;
        #1;
        chk("rst_addr", 64'(vram_addr), 64'h0);
        chk("rst_int_n", 64'(int_n), 64'h1);
        chk("rst_regs", regs, 64'h0);
        chk("rst_readbuf", 64'(cpu.io_dout), 64'h0);
        chk("rst_pulses", 64'(we_cnt + re_cnt), 64'h0);

        // address load without prefetch, then a data write
        io_wr(8'h99, 8'h00);
        io_wr(8'h99, 8'h40);
        chk("ld_no_prefetch", 64'(re_cnt), 64'h0);
        io_wr(8'h98, 8'hAA);
        chk("wr_cnt", 64'(we_cnt), 64'h1);
        chk("wr_addr", 64'(we_addr), 64'h0);
        chk("wr_data", 64'(we_data), 64'hAA);
        chk("wr_inc", 64'(vram_addr), 64'h1);

        // register write, interrupt, status read
        io_wr(8'h99, 8'hE0);
        io_wr(8'h99, 8'h81);
        chk("reg1", regs, 64'h0000_0000_0000_E000);
        chk("int_idle", 64'(int_n), 64'h1);
        @(negedge clk); vblank = 1'b1;
        @(negedge clk); vblank = 1'b0;
        @(negedge clk);
        chk("int_assert", 64'(int_n), 64'h0);
        cpu.io_addr = 8'h99;
        cpu.io_rd_n = 1'b0;
        #1;
        chk("stat_f", 64'(cpu.io_dout), 64'h80);
        chk("io_sel", 64'(cpu.io_sel), 64'h1);
        @(negedge clk);
        chk("int_hold", 64'(int_n), 64'h0);
        cpu.io_rd_n = 1'b1;
        @(negedge clk);
        chk("int_release", 64'(int_n), 64'h1);

        // vblank coinciding with a status read keeps F set
        @(negedge clk);
        cpu.io_addr = 8'h99; cpu.io_rd_n = 1'b0; vblank = 1'b1;
        @(negedge clk);
        cpu.io_rd_n = 1'b1; vblank = 1'b0;
        @(negedge clk);
        io_rd(8'h99, d);
        chk("stat_vbl_win", 64'(d), 64'h80);
        io_rd(8'h99, d);
        chk("stat_cleared", 64'(d), 64'h00);

        // prefetch at 3FFF, read returns it, address wraps to 0000
        mem_lat = 3;
        re0 = re_cnt;
        io_wr(8'h99, 8'hFF);
        io_wr(8'h99, 8'h3F);
        chk("pf_cnt", 64'(re_cnt - re0), 64'h1);
        chk("pf_addr", 64'(re_addr), 64'h3FFF);
        repeat (6) @(negedge clk);
        io_rd(8'h98, d);
        chk("pf_data", 64'(d), 64'h5A);
        chk("rd_pf_addr", 64'(re_addr), 64'h0000);
        chk("rd_wrap", 64'(vram_addr), 64'h0000);
        io_rd(8'h98, d);
        chk("rd_pending", 64'(d), 64'h5A);
        repeat (10) @(negedge clk);

        // write while a prefetch is pending drops the late read data
        mem_lat = 4;
        io_wr(8'h99, 8'h10);
        io_wr(8'h99, 8'h00);
        chk("pf2_addr", 64'(re_addr), 64'h0010);
        io_wr(8'h98, 8'h3C);
        chk("wr2_addr", 64'(we_addr), 64'h0010);
        repeat (8) @(negedge clk);
        io_rd(8'h98, d);
        chk("wr_clr_pend", 64'(d), 64'h3C);
        repeat (8) @(negedge clk);

        // held strobe gives one access; no access while clk_ena is low
        we0 = we_cnt;
        @(negedge clk);
        cpu.io_addr = 8'h98; cpu.io_din = 8'h11; cpu.io_wr_n = 1'b0;
        repeat (4) @(negedge clk);
        cpu.io_wr_n = 1'b1;
        @(negedge clk);
        chk("held_strobe", 64'(we_cnt - we0), 64'h1);
        we0 = we_cnt;
        clk_ena = 1'b0;
        cpu.io_wr_n = 1'b0;
        repeat (2) @(negedge clk);
        cpu.io_wr_n = 1'b1;
        @(negedge clk);
        clk_ena = 1'b1;
        @(negedge clk);
        chk("ena_gate", 64'(we_cnt - we0), 64'h0);

        // register index range and latch reset by other accesses
        io_wr(8'h99, 8'h55);
        io_wr(8'h99, 8'h88);
        chk("reg_oob", regs, 64'h0000_0000_0000_E000);
        io_wr(8'h99, 8'h12);
        io_rd(8'h99, d);
        io_wr(8'h99, 8'h34);
        io_wr(8'h99, 8'h80);
        chk("latch_stat", regs, 64'h0000_0000_0000_E034);
        io_wr(8'h99, 8'h56);
        io_rd(8'h98, d);
        io_wr(8'h99, 8'h07);
        io_wr(8'h99, 8'h82);
        chk("latch_data", regs, 64'h0000_0000_0007_E034);
        repeat (8) @(negedge clk);

        // high address bits from register 14
        io_wr(8'h99, 8'h01);
        io_wr(8'h99, 8'h8E);
        io_wr(8'h99, 8'h00);
        io_wr(8'h99, 8'h40);
        chk("hi_reg14", 64'(regs17[119:112]), 64'h01);
        chk("hi_addr17", 64'(vram_addr17), 64'h04000);
        chk("hi_addr14", 64'(vram_addr), 64'h0000);
        chk("reg14_oob", regs, 64'h0000_0000_0007_E034);

        // reset during a pending fetch
        @(negedge clk); vblank = 1'b1;
        @(negedge clk); vblank = 1'b0;
        repeat (2) @(negedge clk);
        chk("int_pre_rst", 64'(int_n), 64'h0);
        mem_lat = 6;
        io_wr(8'h99, 8'h05);
        io_wr(8'h99, 8'h00);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("rst2_regs", regs, 64'h0);
        chk("rst2_addr", 64'(vram_addr), 64'h0);
        chk("rst2_int_n", 64'(int_n), 64'h1);
        repeat (6) @(negedge clk);
        io_rd(8'h99, d);
        chk("rst2_f", 64'(d), 64'h00);
        io_rd(8'h98, d);
        chk("rst2_pend_drop", 64'(d), 64'h00);
        repeat (10) @(negedge clk);

        // strobe already low when reset releases
        we0 = we_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        cpu.io_addr = 8'h98; cpu.io_din = 8'h77; cpu.io_wr_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        cpu.io_wr_n = 1'b1;
        @(negedge clk);
        chk("rel_cnt", 64'(we_cnt - we0), 64'h1);
        chk("rel_data", 64'(we_data), 64'h77);
        chk("rel_addr", 64'(we_addr), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
